// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and framing constants
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int BITS_PER_BYTE  = 8;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word-fall-through read data
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the pre-edge count, so a push at full is refused even when a pop lands on the same edge.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_send_responder.sv
// rtl/uart_send_responder.sv - buffers 32-bit words and sends each as four 8N1 frames, MSB byte first
module uart_send_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send_en,
  input  logic [31:0] send_data,
  output logic        send_busy,
  output logic        overflow,
  output logic        txd,
  output logic        tx_idle
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(BITS_PER_BYTE - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  tx_state_t     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [31:0]   shift_q;
  logic [7:0]    cur_byte;

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [31:0]   fifo_rd_data;
  logic [CW-1:0] fifo_count;
  logic          push_ok;

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (send_en),
    .push_data (send_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign push_ok   = send_en && !fifo_full;
  assign fifo_pop  = (state == IDLE) && (fifo_count != '0);
  assign send_busy = fifo_full;
  assign cur_byte  = shift_q[31:24];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shift_q  <= '0;
      txd      <= 1'b1;
      tx_idle  <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (send_en && fifo_full) overflow <= 1'b1;
      tx_idle <= 1'b0;
      case (state)
        IDLE: begin
          baud <= '0;
          txd  <= 1'b1;
          if (fifo_pop) begin
            shift_q  <= fifo_rd_data;
            byte_idx <= '0;
            bit_idx  <= '0;
            txd      <= 1'b0;
            state    <= START;
          end else begin
            // Stays idle only if nothing lands in the FIFO on this same edge.
            tx_idle <= fifo_empty && !push_ok;
          end
        end
        START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= '0;
            txd     <= cur_byte[0];
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == LAST_BIT) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (byte_idx == LAST_BYTE) begin
              txd     <= 1'b1;
              tx_idle <= fifo_empty && !push_ok;
              state   <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              shift_q  <= {shift_q[23:0], 8'h00};
              txd      <= 1'b0;
              state    <= START;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
